button_arbiter: RTL and testbench

Sequential controller that shares the three on-board LEDs between three active-low push buttons. Each raw button is synchronised and debounced, then an arbiter grants exactly one LED at a time using round-robin priority and holds the grant for a minimum time. It sits between the board button pins and the LED pins and replaces direct combinational button-to-LED decoding.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_debounce.sv | 50 +++++
 rtl/button_arbiter.sv | 113 +++++++++++
 tb/tb_button_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the button-to-LED arbiter.
package button_pkg;

  // Arbiter FSM states: no LED lit, or one LED granted to its owner.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Number of buttons/LEDs on this board.
  localparam int NUM_BTN_DEF = 3;

  // Bit width needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Width of the owner and round-robin pointer for the default board.
  localparam int PTR_W_DEF = clog2_min1(NUM_BTN_DEF);

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for one
// active-low button. The debounced level only moves after the synchronised
// level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_db_n
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw pin into the clock domain; released (1) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_btn_n;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive disagreements; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db  <= 1'b1;
      r_cnt <= '0;
    end else if (r_s2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db  <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_db_n = r_db;

endmodule

// File: rtl/button_arbiter.sv
// Shares the LEDs between debounced active-low buttons. One LED is granted
// at a time in round-robin order starting after the previous owner, and each
// grant is held for at least HOLD_CYCLES cycles. Non-owner presses during a
// grant are not remembered; they compete again only once IDLE is re-entered.
module button_arbiter
  import button_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] button,
  output logic [NUM_BTN-1:0] LED,
  output logic               busy
);

  localparam int PTR_W  = clog2_min1(NUM_BTN);
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES);

  logic [NUM_BTN-1:0] w_db_n;
  logic [NUM_BTN-1:0] w_pressed;
  logic [PTR_W-1:0]   w_pick;
  logic [NUM_BTN-1:0] w_pick_onehot;
  logic               w_owner_pressed;
  logic               w_hold_done;

  arb_state_e         r_state;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_last;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [NUM_BTN-1:0] r_led;
  logic               r_busy;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn_n(button[g]),
        .o_db_n (w_db_n[g])
      );
    end
  endgenerate

  assign w_pressed       = ~w_db_n;
  assign w_owner_pressed = w_pressed[r_owner];
  assign w_hold_done     = (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign w_pick_onehot   = {{(NUM_BTN-1){1'b0}}, 1'b1} << w_pick;

  // Round-robin search from last+1; farthest candidates are scanned first so
  // the nearest pressed button overwrites them and wins.
  always_comb begin
    w_pick = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      w_pick = w_pressed[PTR_W'((int'(r_last) + k) % NUM_BTN)]
             ? PTR_W'((int'(r_last) + k) % NUM_BTN)
             : w_pick;
    end
  end

  // Grant FSM with registered LED/busy outputs and saturating hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= PTR_W'(NUM_BTN - 1);
      r_hold_cnt <= '0;
      r_led      <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pressed) begin
            r_owner    <= w_pick;
            r_led      <= w_pick_onehot;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
            r_state    <= GRANT;
          end else begin
            r_led  <= '0;
            r_busy <= 1'b0;
          end
        end
        GRANT: begin
          if (w_hold_done && !w_owner_pressed) begin
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
            r_state <= IDLE;
          end else if (!w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end else begin
            r_hold_cnt <= r_hold_cnt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_led   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign LED  = r_led;
  assign busy = r_busy;

endmodule

// File: tb/tb_button_arbiter.sv
// Scoreboard bench for button_arbiter: a behavioural model predicts LED/busy
// for every clock edge, a monitor compares on the falling edge.
module tb_button_arbiter;

  localparam int N    = 3;
  localparam int DB   = 4;
  localparam int HOLD = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] button;
  logic [N-1:0] LED;
  logic         busy;

  int n_tests;
  int n_fail;
  bit started;

  logic [N:0]   exp_q[$];     // {busy, LED}
  logic [N-1:0] samp_q[$];    // raw samples, newest at index 0
  logic [N-1:0] m_db;
  bit           m_granted;
  int           m_owner;
  int           m_last;
  int           m_grant_edge;
  int           m_edge;

  button_arbiter #(
    .NUM_BTN        (N),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .button(button),
    .LED   (LED),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    samp_q.delete();
    for (int k = 0; k < 2 + DB; k++) samp_q.push_back({N{1'b1}});
    m_db         = {N{1'b1}};
    m_granted    = 1'b0;
    m_owner      = 0;
    m_last       = N - 1;
    m_grant_edge = 0;
    m_edge       = 0;
  endfunction

  function automatic logic [N:0] model_out();
    logic [N-1:0] led;
    led = '0;
    if (m_granted) led[m_owner] = 1'b1;
    return {m_granted, led};
  endfunction

  // One active clock edge of the reference behaviour.
  function automatic void model_step(input logic [N-1:0] raw);
    logic [N-1:0] pressed;
    bit found;
    int idx;
    bit all_diff;
    pressed = ~m_db;
    if (!m_granted) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && pressed[idx]) begin
          found        = 1'b1;
          m_granted    = 1'b1;
          m_owner      = idx;
          m_grant_edge = m_edge;
        end
      end
    end else if ((m_edge - m_grant_edge) >= HOLD && !pressed[m_owner]) begin
      m_granted = 1'b0;
      m_last    = m_owner;
    end
    // s2 seen at this edge is the raw pin sampled two edges earlier; the
    // debounced level flips once DB consecutive s2 samples disagree with it.
    samp_q.push_front(raw);
    void'(samp_q.pop_back());
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if (samp_q[2 + k][i] == m_db[i]) all_diff = 1'b0;
      end
      if (all_diff) m_db[i] = ~m_db[i];
    end
    m_edge++;
  endfunction

  // Reference model: advances on each clock edge, resets asynchronously.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(model_out());
      end else begin
        model_step(button);
        exp_q.push_back(model_out());
      end
      started = 1'b1;
    end
  end

  // Monitor: compare the DUT to the oldest prediction on every falling edge.
  initial begin
    logic [N:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_led", int'(LED), int'(e[N-1:0]));
        check("sb_busy", int'(busy), int'(e[N]));
      end else if (started) begin
        check("sb_underflow", 0, 1);
      end
    end
  end

  task automatic run(input logic [N-1:0] b, input int cycles);
    button = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Count edges from a negedge-applied change until any LED lights.
  task automatic measure(output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (LED != '0 && lat < 0) lat = k;
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int waited;
    n_tests = 0;
    n_fail  = 0;
    started = 1'b0;
    rst_n   = 1'b0;
    button  = 3'b000;

    // Reset with all buttons pressed, then idle with all released.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(3'b111, 20);

    // Single press of button 0: grant appears 2+DB edges after press.
    button = 3'b110;
    measure(lat);
    check("press_latency", lat, 2 + DB);
    run(3'b110, 9);
    run(3'b111, 20);

    // Glitch on button 1 shorter than the debounce window.
    run(3'b101, 3);
    run(3'b111, 15);

    // Short press on button 2 still gets the full hold time.
    run(3'b011, 6);
    run(3'b111, 25);

    // Contention from reset: buttons 0 and 2, brief late press of button 1.
    rst_n = 1'b0;
    run(3'b111, 2);
    rst_n = 1'b1;
    run(3'b010, 10);
    run(3'b000, 5);
    run(3'b010, 5);
    run(3'b011, 30);
    run(3'b111, 25);

    // Asynchronous reset in the middle of a grant to button 1.
    button = 3'b101;
    waited = 0;
    while (LED != 3'b010 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("grant_b1_timeout", int'(waited < 40), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(LED), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure(lat);
    check("regrant_latency", lat, 2 + DB);
    run(3'b101, 5);
    run(3'b111, 25);

    // Randomised button activity.
    for (int it = 0; it < 150; it++) begin
      run(3'($urandom_range(0, 7)), int'($urandom_range(1, 25)));
    end
    run(3'b111, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
